// File: rtl/z80_bus_bridge.sv
// Z80 strobe-to-handshake bridge: synchronizes the CPU control strobes and turns each
// CPU bus cycle into exactly one req/ack transaction on a memory or I/O port.
module z80_bus_bridge #(
    parameter int          SYNC_STAGES = 2,
    parameter int          TIMEOUT     = 15,
    parameter logic [7:0]  IM_VECTOR   = 8'hFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] z_a,
    input  logic [7:0]  z_d_in,
    output logic [7:0]  z_d_out,
    output logic        z_d_oe,
    input  logic        z_nmreq,
    input  logic        z_niorq,
    input  logic        z_nrd,
    input  logic        z_nwr,
    input  logic        z_nm1,
    input  logic        z_nrfsh,
    output logic        z_nwait,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        io_req,
    output logic        io_we,
    output logic [15:0] io_addr,
    output logic [7:0]  io_wdata,
    input  logic        io_ack,
    input  logic [7:0]  io_rdata,
    output logic        bus_err,
    output logic [1:0]  o_dbg_state
);

    // Handshake: req is a level held until the single-cycle ack of that same port is
    // sampled; req is low the cycle after; acks seen outside REQ or on the idle port are dropped.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [5:0]  r_sync [SYNC_STAGES];
    logic [7:0]  r_cnt;
    logic [15:0] r_addr;
    logic [7:0]  r_wdata;
    logic [7:0]  r_d_out;
    logic        r_we;
    logic        r_is_rd;
    logic        r_is_inta;
    logic        r_mem_req;
    logic        r_io_req;
    logic        r_nwait;
    logic        r_bus_err;

    logic w_nmreq, w_niorq, w_nrd, w_nwr, w_nm1, w_nrfsh;
    logic w_inta, w_memwr, w_memrd, w_iowr, w_iord, w_any, w_bus_idle;
    logic w_cls_io, w_cls_we, w_sel_ack;
    logic w_start, w_inta_hit, w_ack, w_timeout;

    // Only the strobes are synchronized; address and data are stable once a strobe is seen.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '1;
        end else begin
            r_sync[0] <= {z_nmreq, z_niorq, z_nrd, z_nwr, z_nm1, z_nrfsh};
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    assign {w_nmreq, w_niorq, w_nrd, w_nwr, w_nm1, w_nrfsh} = r_sync[SYNC_STAGES-1];

    assign w_inta     = !w_niorq && !w_nm1;
    assign w_memwr    = !w_nmreq && !w_nwr;
    assign w_memrd    = !w_nmreq && !w_nrd && w_nrfsh;
    assign w_iowr     = !w_niorq && !w_nwr;
    assign w_iord     = !w_niorq && !w_nrd && w_nm1;
    assign w_any      = w_memwr || w_memrd || w_iowr || w_iord;
    assign w_bus_idle = w_nmreq && w_niorq && w_nrd && w_nwr;
    assign w_cls_io   = !(w_memwr || w_memrd);
    assign w_cls_we   = w_memwr || (w_cls_io && w_iowr);
    assign w_sel_ack  = (r_mem_req && mem_ack) || (r_io_req && io_ack);

    always_ff @(posedge clock) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_inta_hit  = 1'b0;
        w_ack       = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_inta) begin
                    w_state_nxt = ST_HOLD;
                    w_inta_hit  = 1'b1;
                end else if (w_any) begin
                    w_state_nxt = ST_REQ;
                    w_start     = 1'b1;
                end
            end
            ST_REQ: begin
                // Ack is tested first so an ack in the final counted cycle wins over timeout.
                if (w_sel_ack) begin
                    w_state_nxt = ST_HOLD;
                    w_ack       = 1'b1;
                end else if (r_cnt >= LP_LAST) begin
                    w_state_nxt = ST_HOLD;
                    w_timeout   = 1'b1;
                end
            end
            ST_HOLD: begin
                if (w_bus_idle) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt     <= 8'd0;
            r_addr    <= 16'd0;
            r_wdata   <= 8'd0;
            r_d_out   <= 8'd0;
            r_we      <= 1'b0;
            r_is_rd   <= 1'b0;
            r_is_inta <= 1'b0;
            r_mem_req <= 1'b0;
            r_io_req  <= 1'b0;
            r_nwait   <= 1'b1;
            r_bus_err <= 1'b0;
        end else begin
            r_bus_err <= 1'b0;
            if (w_start) begin
                r_addr    <= z_a;
                r_wdata   <= z_d_in;
                r_we      <= w_cls_we;
                r_is_rd   <= !w_cls_we;
                r_is_inta <= 1'b0;
                r_cnt     <= 8'd0;
                r_mem_req <= !w_cls_io;
                r_io_req  <= w_cls_io;
                r_nwait   <= 1'b0;
            end
            if (w_inta_hit) begin
                r_d_out   <= IM_VECTOR;
                r_is_inta <= 1'b1;
                r_is_rd   <= 1'b0;
            end
            if (r_state == ST_REQ && !w_ack && !w_timeout) r_cnt <= r_cnt + 8'd1;
            if (w_ack || w_timeout) begin
                r_mem_req <= 1'b0;
                r_io_req  <= 1'b0;
                r_nwait   <= 1'b1;
            end
            if (w_ack && r_is_rd) r_d_out <= r_io_req ? io_rdata : mem_rdata;
            if (w_timeout) begin
                r_d_out   <= 8'hFF;
                r_bus_err <= 1'b1;
            end
        end
    end

    assign z_d_oe = (r_state == ST_HOLD) &&
                    ((r_is_rd && !w_nrd) || (r_is_inta && !w_niorq));

    assign z_d_out     = r_d_out;
    assign z_nwait     = r_nwait;
    assign mem_req     = r_mem_req;
    assign mem_we      = r_we;
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;
    assign io_req      = r_io_req;
    assign io_we       = r_we;
    assign io_addr     = r_addr;
    assign io_wdata    = r_wdata;
    assign bus_err     = r_bus_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_z80_bus_bridge.sv
// Bench for z80_bus_bridge: directed vector table, hand sequences for refresh and
// mid-transaction reset, and randomized transactions against a cycle-count model.
module tb_z80_bus_bridge;

    localparam int TIMEOUT = 15;
    localparam int W       = 25;

    localparam int P_NONE = 0;
    localparam int P_MEM  = 1;
    localparam int P_IO   = 2;

    localparam int C_NONE  = 0;
    localparam int C_MEMRD = 1;
    localparam int C_MEMWR = 2;
    localparam int C_IORD  = 3;
    localparam int C_IOWR  = 4;
    localparam int C_INTA  = 5;

    // strobe order {nmreq, niorq, nrd, nwr, nm1, nrfsh}
    localparam logic [5:0] S_MEMRD = 6'b010111;
    localparam logic [5:0] S_MEMWR = 6'b011011;
    localparam logic [5:0] S_IORD  = 6'b100111;
    localparam logic [5:0] S_IOWR  = 6'b101011;
    localparam logic [5:0] S_INTA  = 6'b101101;
    localparam logic [5:0] S_RFSH  = 6'b011110;
    localparam logic [5:0] S_M1RD  = 6'b010101;
    localparam logic [5:0] S_IDLE  = 6'b111111;

    typedef struct {
        logic [5:0]  strb;
        logic [15:0] addr;
        logic [7:0]  wdata;
        int          delay;
        logic [7:0]  rdata;
        int          exp_port;
        logic        exp_we;
        int          exp_reqc;
        logic        exp_berr;
        logic [7:0]  exp_dout;
        logic        exp_doe;
    } vec_t;

    logic        clock, reset;
    logic [15:0] z_a;
    logic [7:0]  z_d_in, z_d_out;
    logic        z_d_oe;
    logic        z_nmreq, z_niorq, z_nrd, z_nwr, z_nm1, z_nrfsh, z_nwait;
    logic        mem_req, mem_we, mem_ack;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        io_req, io_we, io_ack;
    logic [15:0] io_addr;
    logic [7:0]  io_wdata, io_rdata;
    logic        bus_err;
    logic [1:0]  o_dbg_state;

    int         n_vec  = 0;
    int         n_fail = 0;
    logic [7:0] m_dout;
    vec_t       tbl [$];

    z80_bus_bridge #(.SYNC_STAGES(2), .TIMEOUT(TIMEOUT), .IM_VECTOR(8'hFF)) dut (
        .clock(clock), .reset(reset), .z_a(z_a), .z_d_in(z_d_in), .z_d_out(z_d_out),
        .z_d_oe(z_d_oe), .z_nmreq(z_nmreq), .z_niorq(z_niorq), .z_nrd(z_nrd),
        .z_nwr(z_nwr), .z_nm1(z_nm1), .z_nrfsh(z_nrfsh), .z_nwait(z_nwait),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .io_req(io_req), .io_we(io_we),
        .io_addr(io_addr), .io_wdata(io_wdata), .io_ack(io_ack), .io_rdata(io_rdata),
        .bus_err(bus_err), .o_dbg_state(o_dbg_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_strb(input logic [5:0] s);
        {z_nmreq, z_niorq, z_nrd, z_nwr, z_nm1, z_nrfsh} = s;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(logic [5:0] s, logic [15:0] a, logic [7:0] wd, int d,
                                 logic [7:0] rd, int p, logic we, int rc, logic be,
                                 logic [7:0] dout, logic doe);
        vec_t v;
        v.strb = s; v.addr = a; v.wdata = wd; v.delay = d; v.rdata = rd;
        v.exp_port = p; v.exp_we = we; v.exp_reqc = rc; v.exp_berr = be;
        v.exp_dout = dout; v.exp_doe = doe;
        return v;
    endfunction

    // Bus-cycle class straight from the strobe rules, highest priority first.
    function automatic int classify(logic [5:0] s);
        logic nmreq, niorq, nrd, nwr, nm1, nrfsh;
        {nmreq, niorq, nrd, nwr, nm1, nrfsh} = s;
        if (!niorq && !nm1)               return C_INTA;
        if (!nmreq && !nwr)               return C_MEMWR;
        if (!nmreq && !nrd && nrfsh)      return C_MEMRD;
        if (!niorq && !nwr)               return C_IOWR;
        if (!niorq && !nrd && nm1)        return C_IORD;
        return C_NONE;
    endfunction

    task automatic predict(inout vec_t v);
        int  cls;
        logic tmo;
        cls = classify(v.strb);
        v.exp_port = (cls == C_MEMRD || cls == C_MEMWR) ? P_MEM :
                     (cls == C_IORD  || cls == C_IOWR)  ? P_IO  : P_NONE;
        v.exp_we   = (cls == C_MEMWR || cls == C_IOWR);
        tmo        = (v.exp_port != P_NONE) && (v.delay >= TIMEOUT);
        v.exp_reqc = (v.exp_port == P_NONE) ? 0 : (tmo ? TIMEOUT : v.delay + 1);
        v.exp_berr = tmo;
        if (cls == C_INTA || tmo)                   m_dout = 8'hFF;
        else if (cls == C_MEMRD || cls == C_IORD)   m_dout = v.rdata;
        v.exp_dout = m_dout;
        v.exp_doe  = (cls == C_MEMRD || cls == C_IORD || cls == C_INTA);
    endtask

    // Drive one CPU bus cycle for W clocks, respond to req after v.delay cycles,
    // sprinkle acks on ports that are not requesting, then release the strobes.
    task automatic run_txn(input vec_t v, input string tag);
        int mem_c = 0, io_c = 0, nw_c = 0, be_c = 0, oe_c = 0, first = -1;
        logic        we_s = 1'b0;
        logic [15:0] addr_s = 16'h0;
        logic [7:0]  wd_s = 8'h0, dout_s;
        z_a = v.addr;
        z_d_in = v.wdata;
        mem_ack = 1'b0;
        io_ack = 1'b0;
        set_strb(v.strb);
        for (int t = 1; t <= W; t++) begin
            tick();
            mem_ack = 1'b0;
            io_ack = 1'b0;
            mem_rdata = 8'($urandom);
            io_rdata = 8'($urandom);
            if (mem_req === 1'b1) begin
                if (first < 0) first = t;
                if (mem_c == 0) begin
                    we_s = mem_we; addr_s = mem_addr; wd_s = mem_wdata;
                end
                if (mem_c == v.delay) begin
                    mem_ack = 1'b1;
                    mem_rdata = v.rdata;
                end
                mem_c++;
            end else if ($urandom_range(0, 3) == 0) begin
                mem_ack = 1'b1;
            end
            if (io_req === 1'b1) begin
                if (first < 0) first = t;
                if (io_c == 0) begin
                    we_s = io_we; addr_s = io_addr; wd_s = io_wdata;
                end
                if (io_c == v.delay) begin
                    io_ack = 1'b1;
                    io_rdata = v.rdata;
                end
                io_c++;
            end else if ($urandom_range(0, 3) == 0) begin
                io_ack = 1'b1;
            end
            if (z_nwait === 1'b0) nw_c++;
            if (bus_err === 1'b1) be_c++;
            if (z_d_oe === 1'b1)  oe_c++;
        end
        dout_s = z_d_out;
        chk({tag, " mem_req cycles"}, mem_c, (v.exp_port == P_MEM) ? v.exp_reqc : 0);
        chk({tag, " io_req cycles"}, io_c, (v.exp_port == P_IO) ? v.exp_reqc : 0);
        if (v.exp_port != P_NONE) begin
            chk({tag, " req latency"}, first, 3);
            chk({tag, " we"}, we_s, v.exp_we);
            chk({tag, " addr"}, addr_s, v.addr);
            if (v.exp_we) chk({tag, " wdata"}, wd_s, v.wdata);
        end
        chk({tag, " nwait low cycles"}, nw_c, v.exp_reqc);
        chk({tag, " bus_err pulses"}, be_c, v.exp_berr);
        chk({tag, " d_oe cycles"}, oe_c, v.exp_doe ? (W - 2 - v.exp_reqc) : 0);
        chk({tag, " d_out"}, dout_s, v.exp_dout);

        set_strb(S_IDLE);
        for (int t = 1; t <= 4; t++) begin
            tick();
            mem_ack = (t == 1);
            io_ack = (t == 1);
            mem_rdata = 8'($urandom);
            io_rdata = 8'($urandom);
        end
        chk({tag, " post d_oe"}, z_d_oe, 1'b0);
        chk({tag, " post state"}, o_dbg_state, 2'd0);
        chk({tag, " post d_out"}, z_d_out, v.exp_dout);
    endtask

    initial begin
        int   mem_c, io_c, seen;
        vec_t v;
        logic [5:0] cls_strb [6];

        reset = 1'b1;
        set_strb(S_IDLE);
        z_a = 16'h0; z_d_in = 8'h0;
        mem_ack = 1'b0; io_ack = 1'b0; mem_rdata = 8'h0; io_rdata = 8'h0;
        repeat (3) tick();
        chk("rst nwait", z_nwait, 1'b1);
        chk("rst d_oe", z_d_oe, 1'b0);
        chk("rst d_out", z_d_out, 8'h00);
        chk("rst reqs", {mem_req, io_req}, 2'b00);
        chk("rst we", {mem_we, io_we}, 2'b00);
        chk("rst addr", {mem_addr, io_addr}, 32'h0);
        chk("rst wdata", {mem_wdata, io_wdata}, 16'h0);
        chk("rst bus_err", bus_err, 1'b0);
        chk("rst state", o_dbg_state, 2'd0);
        reset = 1'b0;
        tick();

        tbl.push_back(mkv(S_MEMRD, 16'h1234, 8'h00, 3,   8'hA5, P_MEM, 0, 4,  0, 8'hA5, 1));
        tbl.push_back(mkv(S_MEMWR, 16'hC000, 8'h3C, 0,   8'h00, P_MEM, 1, 1,  0, 8'hA5, 0));
        tbl.push_back(mkv(S_IORD,  16'h00FE, 8'h00, 255, 8'h00, P_IO,  0, 15, 1, 8'hFF, 1));
        tbl.push_back(mkv(S_IOWR,  16'h0042, 8'h99, 2,   8'h00, P_IO,  1, 3,  0, 8'hFF, 0));
        tbl.push_back(mkv(S_MEMRD, 16'h8000, 8'h00, 1,   8'h5A, P_MEM, 0, 2,  0, 8'h5A, 1));
        tbl.push_back(mkv(S_INTA,  16'h0000, 8'h00, 0,   8'h00, P_NONE,0, 0,  0, 8'hFF, 1));
        tbl.push_back(mkv(S_IORD,  16'h0010, 8'h00, 14,  8'h77, P_IO,  0, 15, 0, 8'h77, 1));
        tbl.push_back(mkv(S_MEMWR, 16'h1111, 8'h55, 20,  8'h00, P_MEM, 1, 15, 1, 8'hFF, 0));
        tbl.push_back(mkv(S_MEMRD, 16'h0100, 8'h00, 0,   8'h3E, P_MEM, 0, 1,  0, 8'h3E, 1));
        tbl.push_back(mkv(6'b010011, 16'h2000, 8'h81, 0, 8'h00, P_MEM, 1, 1,  0, 8'h3E, 0));
        tbl.push_back(mkv(6'b000101, 16'h4000, 8'h00, 0, 8'h00, P_NONE,0, 0,  0, 8'hFF, 1));
        tbl.push_back(mkv(6'b000011, 16'h7777, 8'h24, 4, 8'h00, P_MEM, 1, 5,  0, 8'hFF, 0));
        foreach (tbl[i]) begin
            run_txn(tbl[i], $sformatf("vec%0d", i));
            m_dout = tbl[i].exp_dout;
        end

        // Refresh must not produce a request; the following M1 read gets exactly one.
        set_strb(S_RFSH);
        mem_c = 0; io_c = 0;
        for (int t = 0; t < 6; t++) begin
            tick();
            if (mem_req === 1'b1) mem_c++;
            if (io_req === 1'b1) io_c++;
        end
        chk("rfsh reqs", mem_c + io_c, 0);
        chk("rfsh state", o_dbg_state, 2'd0);
        set_strb(S_IDLE);
        tick();
        run_txn(mkv(S_M1RD, 16'h0038, 8'h00, 1, 8'hC3, P_MEM, 0, 2, 0, 8'hC3, 1), "m1rd");
        m_dout = 8'hC3;

        cls_strb[0] = S_MEMRD; cls_strb[1] = S_MEMWR; cls_strb[2] = S_IORD;
        cls_strb[3] = S_IOWR;  cls_strb[4] = S_INTA;  cls_strb[5] = S_RFSH;
        for (int n = 0; n < 40; n++) begin
            v.strb  = (n % 2 == 0) ? cls_strb[$urandom_range(0, 5)] : 6'($urandom_range(0, 63));
            v.addr  = 16'($urandom);
            v.wdata = 8'($urandom);
            v.rdata = 8'($urandom);
            v.delay = $urandom_range(0, 19);
            predict(v);
            run_txn(v, $sformatf("rnd%0d", n));
        end

        // Reset in the middle of a stalled read; the late ack must be ignored.
        z_a = 16'hBEEF;
        set_strb(S_MEMRD);
        seen = 0;
        for (int t = 0; t < 8 && seen == 0; t++) begin
            tick();
            if (mem_req === 1'b1) seen = 1;
        end
        chk("midrst req seen", seen, 1);
        tick();
        tick();
        reset = 1'b1;
        set_strb(S_IDLE);
        tick();
        chk("midrst mem_req", mem_req, 1'b0);
        chk("midrst nwait", z_nwait, 1'b1);
        chk("midrst state", o_dbg_state, 2'd0);
        reset = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 8'h11;
        tick();
        mem_ack = 1'b0;
        repeat (3) tick();
        chk("midrst late ack req", {mem_req, io_req}, 2'b00);
        chk("midrst late ack d_out", z_d_out, 8'h00);
        chk("midrst late ack state", o_dbg_state, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
